// File: rtl/train_track_model_pkg.sv
// Shared definitions for the two-train track plant model: drive codes,
// status FSM encoding, sensor bit positions and the shared-section test.
package train_track_model_pkg;

  localparam logic [1:0] DRV_STOP = 2'b00;
  localparam logic [1:0] DRV_FWD  = 2'b01;
  localparam logic [1:0] DRV_REV  = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } track_state_e;

  localparam int SR_A_APPROACH = 1;
  localparam int SR_B_APPROACH = 2;
  localparam int SR_B_EXIT     = 3;
  localparam int SR_A_EXIT     = 4;

  // Shared section is strictly between the approach and exit sensors.
  function automatic logic in_shared(input int pos, input int approach_pos,
                                     input int exit_pos);
    return (pos > approach_pos) && (pos < exit_pos);
  endfunction

endpackage

// File: rtl/train_track_model_if.sv
// Controller <-> plant bundle: commands from the controller, sensors, positions,
// fault flags and the plant status state for observation.
interface train_track_model_if
  import train_track_model_pkg::*;
#(
  parameter int POS_W = 4
);
  logic [3:1]       SW;
  logic [1:0]       DA;
  logic [1:0]       DB;
  logic [4:1]       SR;
  logic [POS_W-1:0] POS_A;
  logic [POS_W-1:0] POS_B;
  logic             CRASH;
  logic             DERAIL;
  track_state_e     state;

  modport master (
    output SW, DA, DB,
    input  SR, POS_A, POS_B, CRASH, DERAIL, state
  );

  modport slave (
    input  SW, DA, DB,
    output SR, POS_A, POS_B, CRASH, DERAIL, state
  );
endinterface

// File: rtl/train_track_model_pos_ctr.sv
// Wrap-around up/down position counter for one train; flags the tick on which
// the train steps from outside into the shared section (from either end).
module train_pos_ctr
  import train_track_model_pkg::*;
#(
  parameter int LOOP_LEN     = 16,
  parameter int POS_W        = 4,
  parameter int START        = 0,
  parameter int APPROACH_POS = 4,
  parameter int EXIT_POS     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             halt,
  input  logic [1:0]       drive,
  output logic [POS_W-1:0] pos,
  output logic             entering
);

  localparam logic [POS_W-1:0] LAST = POS_W'(LOOP_LEN - 1);

  logic [POS_W-1:0] pos_nxt;

  always_comb begin
    pos_nxt = pos;
    if (tick && !halt) begin
      case (drive)
        DRV_FWD: pos_nxt = (pos == LAST) ? '0 : pos + POS_W'(1);
        DRV_REV: pos_nxt = (pos == '0) ? LAST : pos - POS_W'(1);
        default: pos_nxt = pos;
      endcase
    end
  end

  // pos_nxt equals pos whenever no move happens, so this is tick-qualified.
  assign entering = !in_shared(int'(pos), APPROACH_POS, EXIT_POS) &&
                    in_shared(int'(pos_nxt), APPROACH_POS, EXIT_POS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pos <= POS_W'(START);
    else     pos <= pos_nxt;
  end

endmodule

// File: rtl/train_track_model.sv
// Two-train shared-section track plant. Build with TRAIN_CRASH_LATCH_EN defined
// to make CRASH/DERAIL sticky and freeze the trains in HALT until RESET.
module train_track_model
  import train_track_model_pkg::*;
#(
  parameter int LOOP_LEN     = 16,
  parameter int POS_W        = 4,
  parameter int APPROACH_POS = 4,
  parameter int EXIT_POS     = 8,
  parameter int STEP_DIV     = 2,
  parameter int A_START      = 0,
  parameter int B_START      = 12
) (
  input  logic                Clock,
  input  logic                RESET,
  train_track_model_if.slave  bus
);

  logic [7:0]       div_cnt;
  logic             tick;
  track_state_e     state, state_nxt;
  logic             halt;
  logic [POS_W-1:0] pos_a, pos_b;
  logic             enter_a, enter_b;
  logic             crash_set, derail_set;
  logic             crash_q, derail_q;

  assign tick = (div_cnt == 8'(STEP_DIV - 1));
  assign halt = (state == ST_HALT);

  always_ff @(posedge Clock or posedge RESET) begin
    if (RESET)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 8'd1;
  end

  train_pos_ctr #(
    .LOOP_LEN(LOOP_LEN), .POS_W(POS_W), .START(A_START),
    .APPROACH_POS(APPROACH_POS), .EXIT_POS(EXIT_POS)
  ) u_pos_a (
    .clk(Clock), .rst(RESET), .tick(tick), .halt(halt),
    .drive(bus.DA), .pos(pos_a), .entering(enter_a)
  );

  train_pos_ctr #(
    .LOOP_LEN(LOOP_LEN), .POS_W(POS_W), .START(B_START),
    .APPROACH_POS(APPROACH_POS), .EXIT_POS(EXIT_POS)
  ) u_pos_b (
    .clk(Clock), .rst(RESET), .tick(tick), .halt(halt),
    .drive(bus.DB), .pos(pos_b), .entering(enter_b)
  );

  // Crash looks at registered positions; derail at the switches during entry.
  assign crash_set  = in_shared(int'(pos_a), APPROACH_POS, EXIT_POS) &&
                      in_shared(int'(pos_b), APPROACH_POS, EXIT_POS);
  assign derail_set = (enter_a && (bus.SW[1] || bus.SW[3])) ||
                      (enter_b && (bus.SW[2] || !bus.SW[3]));

  always_ff @(posedge Clock or posedge RESET) begin
    if (RESET) begin
      crash_q  <= 1'b0;
      derail_q <= 1'b0;
    end else begin
`ifdef TRAIN_CRASH_LATCH_EN
      crash_q  <= crash_q  || crash_set;
      derail_q <= derail_q || derail_set;
`else
      crash_q  <= crash_set;
      derail_q <= derail_set;
`endif
    end
  end

  always_ff @(posedge Clock or posedge RESET) begin
    if (RESET) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // HALT is entered on the same edge the flag rises, so no further move slips in.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
`ifdef TRAIN_CRASH_LATCH_EN
        if (crash_set || derail_set) state_nxt = ST_HALT;
`endif
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    bus.SR                = '0;
    bus.SR[SR_A_APPROACH] = (pos_a == POS_W'(APPROACH_POS));
    bus.SR[SR_A_EXIT]     = (pos_a == POS_W'(EXIT_POS));
    bus.SR[SR_B_APPROACH] = (pos_b == POS_W'(APPROACH_POS));
    bus.SR[SR_B_EXIT]     = (pos_b == POS_W'(EXIT_POS));
  end

  assign bus.POS_A  = pos_a;
  assign bus.POS_B  = pos_b;
  assign bus.CRASH  = crash_q;
  assign bus.DERAIL = derail_q;
  assign bus.state  = state;

endmodule
